// File: rtl/alu_seq.sv
// Command sequencer wrapped around the external 32-bit slice ALU.
// Runs single ALU operations or a 32x32->64 unsigned shift-add multiply through the ALU adder.
module alu_seq #(
    parameter logic [2:0]  ADD_OP    = 3'b000,
    parameter int unsigned EXEC_WAIT = 0
) (
    input  logic        CLK,
    input  logic        N_RST,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic        IN_CMD,
    input  logic [2:0]  IN_OP,
    input  logic [31:0] IN_A,
    input  logic [31:0] IN_B,
    input  logic        IN_C_IN,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [31:0] OUT_LO,
    output logic [31:0] OUT_HI,
    output logic        OUT_Z,
    output logic        OUT_C,
    output logic        OUT_N,
    output logic [31:0] ALU_A,
    output logic [31:0] ALU_B,
    output logic [2:0]  ALU_OP,
    output logic        ALU_C_IN,
    input  logic [31:0] ALU_OUT,
    input  logic        ALU_Z,
    input  logic        ALU_C,
    input  logic        ALU_N
);

    typedef enum logic [2:0] {IDLE, EXEC, MUL_ADD, MUL_SHIFT, RESP} state_t;

    // The first evaluation after accept spends one extra edge loading the ALU registers.
    localparam logic [3:0] WAIT_RELOAD = 4'(EXEC_WAIT);
    localparam logic [3:0] WAIT_FIRST  = 4'(EXEC_WAIT + 1);

    state_t      state_q, state_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic [2:0]  op_q, op_d;
    logic        c_in_q, c_in_d;
    logic [31:0] a_q, a_d;
    logic [31:0] p_q, p_d;
    logic [31:0] q_q, q_d;
    logic [32:0] sum_q, sum_d;
    logic [4:0]  step_q, step_d;
    logic [3:0]  wait_q, wait_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [2:0]  alu_op_q, alu_op_d;
    logic        alu_c_in_q, alu_c_in_d;
    logic [31:0] out_lo_q, out_lo_d;
    logic [31:0] out_hi_q, out_hi_d;
    logic        out_z_q, out_z_d;
    logic        out_c_q, out_c_d;
    logic        out_n_q, out_n_d;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        c_in_d     = c_in_q;
        a_d        = a_q;
        p_d        = p_q;
        q_d        = q_q;
        sum_d      = sum_q;
        step_d     = step_q;
        wait_d     = wait_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        alu_c_in_d = alu_c_in_q;
        out_lo_d   = out_lo_q;
        out_hi_d   = out_hi_q;
        out_z_d    = out_z_q;
        out_c_d    = out_c_q;
        out_n_d    = out_n_q;

        case (state_q)
            IDLE: begin
                if (IN_VALID && in_ready_q) begin
                    // a_q doubles as the multiplicand, q_q as operand B / multiplier
                    op_d    = IN_OP;
                    c_in_d  = IN_C_IN;
                    a_d     = IN_A;
                    q_d     = IN_B;
                    p_d     = '0;
                    step_d  = '0;
                    wait_d  = WAIT_FIRST;
                    state_d = IN_CMD ? MUL_ADD : EXEC;
                end
            end
            EXEC: begin
                alu_a_d    = a_q;
                alu_b_d    = q_q;
                alu_op_d   = op_q;
                alu_c_in_d = c_in_q;
                if (wait_q == '0) begin
                    out_lo_d = ALU_OUT;
                    out_hi_d = '0;
                    out_z_d  = ALU_Z;
                    out_c_d  = ALU_C;
                    out_n_d  = ALU_N;
                    state_d  = RESP;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            MUL_ADD: begin
                alu_a_d    = p_q;
                alu_b_d    = a_q;
                alu_op_d   = ADD_OP;
                alu_c_in_d = 1'b0;
                if (wait_q == '0) begin
                    sum_d   = q_q[0] ? {ALU_C, ALU_OUT} : {1'b0, p_q};
                    state_d = MUL_SHIFT;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            MUL_SHIFT: begin
                {p_d, q_d} = {sum_q, q_q[31:1]};
                step_d     = step_q + 5'd1;
                if (step_q == 5'd31) begin
                    out_hi_d = p_d;
                    out_lo_d = q_d;
                    out_z_d  = ({p_d, q_d} == 64'd0);
                    out_n_d  = p_d[31];
                    out_c_d  = 1'b0;
                    state_d  = RESP;
                end else begin
                    // Present the new partial product now so a zero-wait add sees it.
                    alu_a_d = p_d;
                    wait_d  = WAIT_RELOAD;
                    state_d = MUL_ADD;
                end
            end
            RESP: begin
                if (OUT_READY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == RESP);
    end

    always_ff @(posedge CLK or negedge N_RST) begin
        if (!N_RST) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            op_q        <= '0;
            c_in_q      <= 1'b0;
            a_q         <= '0;
            p_q         <= '0;
            q_q         <= '0;
            sum_q       <= '0;
            step_q      <= '0;
            wait_q      <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            alu_c_in_q  <= 1'b0;
            out_lo_q    <= '0;
            out_hi_q    <= '0;
            out_z_q     <= 1'b0;
            out_c_q     <= 1'b0;
            out_n_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            op_q        <= op_d;
            c_in_q      <= c_in_d;
            a_q         <= a_d;
            p_q         <= p_d;
            q_q         <= q_d;
            sum_q       <= sum_d;
            step_q      <= step_d;
            wait_q      <= wait_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            alu_c_in_q  <= alu_c_in_d;
            out_lo_q    <= out_lo_d;
            out_hi_q    <= out_hi_d;
            out_z_q     <= out_z_d;
            out_c_q     <= out_c_d;
            out_n_q     <= out_n_d;
        end
    end

    assign IN_READY  = in_ready_q;
    assign OUT_VALID = out_valid_q;
    assign OUT_LO    = out_lo_q;
    assign OUT_HI    = out_hi_q;
    assign OUT_Z     = out_z_q;
    assign OUT_C     = out_c_q;
    assign OUT_N     = out_n_q;
    assign ALU_A     = alu_a_q;
    assign ALU_B     = alu_b_q;
    assign ALU_OP    = alu_op_q;
    assign ALU_C_IN  = alu_c_in_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: two instances (zero and three settle cycles), each with an ALU model attached.
module tb_alu_seq;

    typedef struct packed {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        z;
        logic        c;
        logic        n;
    } resp_t;

    logic        clk;
    logic        rst_n;
    logic [1:0]  in_valid;
    logic [1:0]  out_ready;
    logic        in_cmd;
    logic [2:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_cin;

    wire  [1:0]  in_ready;
    wire  [1:0]  out_valid;
    wire  [31:0] out_lo [2];
    wire  [31:0] out_hi [2];
    wire  [1:0]  out_z;
    wire  [1:0]  out_c;
    wire  [1:0]  out_n;
    wire  [31:0] alu_a [2];
    wire  [31:0] alu_b [2];
    wire  [2:0]  alu_op [2];
    wire  [1:0]  alu_cin;
    logic [31:0] alu_out [2];
    logic [1:0]  alu_z;
    logic [1:0]  alu_c;
    logic [1:0]  alu_n;

    int    sel;
    int    n_checks;
    int    n_pass;
    int    n_resp;
    resp_t exp_q[$];

    alu_seq #(.ADD_OP(3'b000), .EXEC_WAIT(0)) u_dut0 (
        .CLK(clk), .N_RST(rst_n),
        .IN_VALID(in_valid[0]), .IN_READY(in_ready[0]), .IN_CMD(in_cmd), .IN_OP(in_op),
        .IN_A(in_a), .IN_B(in_b), .IN_C_IN(in_cin),
        .OUT_VALID(out_valid[0]), .OUT_READY(out_ready[0]), .OUT_LO(out_lo[0]), .OUT_HI(out_hi[0]),
        .OUT_Z(out_z[0]), .OUT_C(out_c[0]), .OUT_N(out_n[0]),
        .ALU_A(alu_a[0]), .ALU_B(alu_b[0]), .ALU_OP(alu_op[0]), .ALU_C_IN(alu_cin[0]),
        .ALU_OUT(alu_out[0]), .ALU_Z(alu_z[0]), .ALU_C(alu_c[0]), .ALU_N(alu_n[0])
    );

    alu_seq #(.ADD_OP(3'b000), .EXEC_WAIT(3)) u_dut3 (
        .CLK(clk), .N_RST(rst_n),
        .IN_VALID(in_valid[1]), .IN_READY(in_ready[1]), .IN_CMD(in_cmd), .IN_OP(in_op),
        .IN_A(in_a), .IN_B(in_b), .IN_C_IN(in_cin),
        .OUT_VALID(out_valid[1]), .OUT_READY(out_ready[1]), .OUT_LO(out_lo[1]), .OUT_HI(out_hi[1]),
        .OUT_Z(out_z[1]), .OUT_C(out_c[1]), .OUT_N(out_n[1]),
        .ALU_A(alu_a[1]), .ALU_B(alu_b[1]), .ALU_OP(alu_op[1]), .ALU_C_IN(alu_cin[1]),
        .ALU_OUT(alu_out[1]), .ALU_Z(alu_z[1]), .ALU_C(alu_c[1]), .ALU_N(alu_n[1])
    );

    always #5 clk = ~clk;

    // ALU behaviour: returns {carry, negative, zero, result}
    function automatic logic [34:0] alu_fn(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic cin);
        logic [32:0] r;
        r = '0;
        case (op)
            3'd0: r = {1'b0, a} + {1'b0, b} + 33'(cin);
            3'd1: r = {1'b0, a} + {1'b0, ~b} + 33'(cin);
            3'd2: r = {1'b0, a & b};
            3'd3: r = {1'b0, a | b};
            3'd4: r = {1'b0, a ^ b};
            3'd5: r = {a[31], a[30:0], 1'b0};
            3'd6: r = {a[0], 1'b0, a[31:1]};
            default: r = {1'b0, b};
        endcase
        return {r[32], r[31], (r[31:0] == 32'd0), r[31:0]};
    endfunction

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            {alu_c[k], alu_n[k], alu_z[k], alu_out[k]} = alu_fn(alu_op[k], alu_a[k], alu_b[k], alu_cin[k]);
        end
    end

    function automatic resp_t ref_model(input logic cmd, input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic cin);
        resp_t       r;
        logic [63:0] p;
        logic [34:0] f;
        if (cmd) begin
            p    = {32'd0, a} * {32'd0, b};
            r.lo = p[31:0];
            r.hi = p[63:32];
            r.z  = (p == 64'd0);
            r.c  = 1'b0;
            r.n  = p[63];
        end else begin
            f    = alu_fn(op, a, b, cin);
            r.lo = f[31:0];
            r.hi = 32'd0;
            r.z  = f[32];
            r.n  = f[33];
            r.c  = f[34];
        end
        return r;
    endfunction

    function automatic logic [136:0] outs_of(input int k);
        return {in_ready[k], out_valid[k], out_lo[k], out_hi[k], out_z[k], out_c[k], out_n[k],
                alu_a[k], alu_b[k], alu_op[k], alu_cin[k]};
    endfunction

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        resp_t act;
        resp_t e;
        if (rst_n && out_valid[sel] && out_ready[sel]) begin
            act = {out_lo[sel], out_hi[sel], out_z[sel], out_c[sel], out_n[sel]};
            check("resp_expected", 160'(exp_q.size() != 0), 160'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("resp_data", 160'(act), 160'(e));
            end
            n_resp++;
        end
    end

    task automatic issue(input logic cmd, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic cin);
        logic ok;
        ok     = 1'b0;
        in_cmd = cmd;
        in_op  = op;
        in_a   = a;
        in_b   = b;
        in_cin = cin;
        in_valid[sel] = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (in_ready[sel]) begin
                ok = 1'b1;
                break;
            end
        end
        check("accept", 160'(ok), 160'(1));
        @(posedge clk);
        #1;
        in_valid[sel] = 1'b0;
        exp_q.push_back(ref_model(cmd, op, a, b, cin));
    endtask

    task automatic wait_valid(input int budget, output int edges, output logic stable,
                              output logic [67:0] snap);
        logic [67:0] cur;
        edges  = 0;
        stable = 1'b1;
        snap   = '0;
        while (edges < budget) begin
            @(posedge clk);
            #1;
            edges++;
            if (out_valid[sel]) break;
            cur = {alu_a[sel], alu_b[sel], alu_op[sel], alu_cin[sel]};
            if (edges == 1) snap = cur;
            else if (cur != snap) stable = 1'b0;
        end
    endtask

    task automatic release_resp();
        out_ready[sel] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[sel] = 1'b0;
    endtask

    task automatic run_random(input int n, input int budget);
        int   issued;
        int   cyc;
        int   resp0;
        logic acc;
        issued = 0;
        cyc    = 0;
        resp0  = n_resp;
        while ((issued < n || exp_q.size() != 0) && cyc < budget) begin
            @(negedge clk);
            acc = in_valid[sel] && in_ready[sel];
            @(posedge clk);
            #1;
            cyc++;
            if (acc) begin
                exp_q.push_back(ref_model(in_cmd, in_op, in_a, in_b, in_cin));
                issued++;
                in_valid[sel] = 1'b0;
            end
            if (!in_valid[sel] && issued < n && $urandom_range(2) == 0) begin
                in_cmd = 1'($urandom_range(1));
                in_op  = 3'($urandom_range(7));
                in_a   = ($urandom_range(3) == 0) ? 32'hFFFF_FFFF : $urandom;
                in_b   = ($urandom_range(3) == 0) ? 32'd0 : $urandom;
                in_cin = 1'($urandom_range(1));
                in_valid[sel] = 1'b1;
            end
            out_ready[sel] = ($urandom_range(3) != 0);
        end
        out_ready[sel] = 1'b0;
        in_valid[sel]  = 1'b0;
        check("rand_issued", 160'(issued), 160'(n));
        check("rand_responses", 160'(n_resp - resp0), 160'(n));
        check("rand_drained", 160'(exp_q.size()), 160'(0));
    endtask

    initial begin
        int          edges;
        logic        stable;
        logic [67:0] snap;
        logic [136:0] hold;
        clk = 1'b0; rst_n = 1'b0; in_valid = '0; out_ready = '0; sel = 0;
        in_cmd = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_cin = 1'b0;
        n_checks = 0; n_pass = 0; n_resp = 0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_outs_w0", 160'(outs_of(0)), 160'(0));
        check("reset_outs_w3", 160'(outs_of(1)), 160'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", 160'({in_ready[0], out_valid[0]}), 160'(2'b10));

        issue(1'b0, 3'b000, 32'hFFFF_FFFF, 32'd1, 1'b0);
        wait_valid(20, edges, stable, snap);
        check("single_latency", 160'(edges), 160'(2));
        check("single_outs", 160'({out_lo[0], out_hi[0], out_z[0], out_c[0], out_n[0]}),
              160'({32'd0, 32'd0, 1'b1, 1'b1, 1'b0}));
        release_resp();

        issue(1'b1, 3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_valid(200, edges, stable, snap);
        check("mul_latency", 160'(edges), 160'(65));
        release_resp();

        issue(1'b1, 3'b000, 32'd0, 32'd12345, 1'b0);
        wait_valid(200, edges, stable, snap);
        check("mul_zero_latency", 160'(edges), 160'(65));
        release_resp();

        // Backpressure with a second command waiting
        issue(1'b0, 3'b010, 32'hF0F0_1234, 32'hFF00_FF00, 1'b0);
        wait_valid(20, edges, stable, snap);
        hold   = outs_of(0);
        in_cmd = 1'b0; in_op = 3'b100; in_a = 32'h1234_5678; in_b = 32'h1234_5678; in_cin = 1'b0;
        in_valid[0] = 1'b1;
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (outs_of(0) != hold || in_ready[0] || !out_valid[0]) stable = 1'b0;
        end
        check("bp_hold", 160'(stable), 160'(1));
        release_resp();
        check("bp_ready_after_hs", 160'({in_ready[0], out_valid[0]}), 160'(2'b10));
        @(posedge clk);
        #1;
        check("bp_second_accepted", 160'(in_ready[0]), 160'(0));
        in_valid[0] = 1'b0;
        exp_q.push_back(ref_model(1'b0, 3'b100, 32'h1234_5678, 32'h1234_5678, 1'b0));
        wait_valid(20, edges, stable, snap);
        check("bp_second_latency", 160'(edges), 160'(2));
        release_resp();

        // Reset around step 10 of a multiply
        issue(1'b1, 3'b000, $urandom | 32'h8000_0001, $urandom | 32'h8000_0001, 1'b0);
        repeat (21) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midmul_reset_outs", 160'(outs_of(0)), 160'(0));
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midmul_ready", 160'({in_ready[0], out_valid[0]}), 160'(2'b10));
        out_ready[0] = 1'b1;
        stable = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (out_valid[0]) stable = 1'b0;
        end
        out_ready[0] = 1'b0;
        check("midmul_no_stale", 160'(stable), 160'(1));

        run_random(40, 20000);

        sel = 1;
        issue(1'b0, 3'b001, 32'd5, 32'd7, 1'b1);
        wait_valid(40, edges, stable, snap);
        check("w3_single_latency", 160'(edges), 160'(5));
        check("w3_alu_stable", 160'(stable), 160'(1));
        check("w3_alu_drive", 160'(snap), 160'({32'd5, 32'd7, 3'b001, 1'b1}));
        release_resp();

        issue(1'b1, 3'b000, 32'd7, 32'd6, 1'b0);
        wait_valid(400, edges, stable, snap);
        check("w3_mul_latency", 160'(edges), 160'(161));
        check("w3_mul_lo", 160'(out_lo[1]), 160'(42));
        release_resp();

        run_random(20, 20000);

        check("final_queue_empty", 160'(exp_q.size()), 160'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
